alu_response_checker: RTL and testbench

//   Synthesizable in-system scoreboard for the ALU pipeline. Snoops the request side
//   (valid_in/a/b/op) and the response side (valid_out/result/zero), queues requests in

---
 rtl/alu_response_checker.sv | 177 +++++++++++++++++
 tb/tb_alu_response_checker.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// alu_response_checker: in-system scoreboard for the ALU pipeline.
// Snoops ALU requests into an in-order queue. Each response is checked against
// the result recomputed for the oldest queued request. Pass/fail pulses,
// saturating counters, sticky error flags and a first-failure capture are kept.
module alu_response_checker #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int OW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  input  logic             rsp_valid,
  input  logic [WIDTH-1:0] rsp_result,
  input  logic             rsp_zero,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_sticky,
  output logic             q_overflow,
  output logic             orphan_rsp,
  output logic [OW-1:0]    outstanding,
  output logic             ff_valid,
  output logic [3:0]       ff_op,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_got,
  output logic [WIDTH-1:0] ff_exp
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  logic [3:0]       q_op [DEPTH];
  logic [WIDTH-1:0] q_a  [DEPTH];
  logic [WIDTH-1:0] q_b  [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    count;

  logic             empty, full, push, pop, ovf;
  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b, exp_res;
  logic             exp_zero, match;
  logic [3:0]       cap_op;
  logic [WIDTH-1:0] cap_a, cap_b, cap_exp;

  assign empty   = (count == '0);
  assign full    = (count == OW'(DEPTH));
  // A response only dequeues when something is queued; an empty-queue
  // response is an orphan and leaves the pointers alone.
  assign pop     = rsp_valid && !empty;
  // A full queue still accepts a request when the head leaves on the same edge.
  assign push    = req_valid && (!full || pop);
  assign ovf     = req_valid && full && !pop;
  assign head_op = q_op[rd_ptr];
  assign head_a  = q_a[rd_ptr];
  assign head_b  = q_b[rd_ptr];
  assign outstanding = count;

  // Expected ALU result for the request at the head of the queue.
  always_comb begin
    exp_res = '0;
    case (head_op)
      4'd0: exp_res = head_a + head_b;
      4'd1: exp_res = head_a - head_b;
      4'd2: exp_res = head_a & head_b;
      4'd3: exp_res = head_a | head_b;
      4'd4: exp_res = head_a ^ head_b;
      4'd5: exp_res = (head_b >= WIDTH_V) ? '0 : (head_a << head_b);
      4'd6: exp_res = (head_b >= WIDTH_V) ? '0 : (head_a >> head_b);
      4'd7: exp_res = {{(WIDTH-1){1'b0}}, (head_a < head_b)};
      4'd8: exp_res = {{(WIDTH-1){1'b0}}, (head_a == head_b)};
      4'd9: exp_res = head_a;
      default: exp_res = '0;
    endcase
    exp_zero = (exp_res == '0);
    // X/Z on the response makes match unknown, which the checker treats as a miss.
    match    = (rsp_result == exp_res) && (rsp_zero == exp_zero);
    // Orphans carry no request, so the captured request fields read as zero.
    cap_op   = empty ? 4'd0 : head_op;
    cap_a    = empty ? '0   : head_a;
    cap_b    = empty ? '0   : head_b;
    cap_exp  = empty ? '0   : exp_res;
  end

  // Queue storage; stale entries beyond the pointers are never read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      q_op[wr_ptr] <= req_op;
      q_a[wr_ptr]  <= req_a;
      q_b[wr_ptr]  <= req_b;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + OW'(push) - OW'(pop);
    end
  end

  // Response verdict, counters, sticky flags and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_pass   <= 1'b0;
      chk_fail   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      err_sticky <= 1'b0;
      q_overflow <= 1'b0;
      orphan_rsp <= 1'b0;
      ff_valid   <= 1'b0;
      ff_op      <= '0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_got     <= '0;
      ff_exp     <= '0;
    end else if (clear) begin
      chk_pass   <= 1'b0;
      chk_fail   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      err_sticky <= 1'b0;
      q_overflow <= 1'b0;
      orphan_rsp <= 1'b0;
      ff_valid   <= 1'b0;
      ff_op      <= '0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_got     <= '0;
      ff_exp     <= '0;
    end else begin
      chk_pass <= 1'b0;
      chk_fail <= 1'b0;
      if (ovf) begin
        q_overflow <= 1'b1;
        err_sticky <= 1'b1;
      end
      if (rsp_valid) begin
        if (!empty && match) begin
          chk_pass <= 1'b1;
          if (pass_count != '1) pass_count <= pass_count + 1'b1;
        end else begin
          chk_fail   <= 1'b1;
          err_sticky <= 1'b1;
          if (fail_count != '1) fail_count <= fail_count + 1'b1;
          if (empty) orphan_rsp <= 1'b1;
          if (!ff_valid) begin
            ff_valid <= 1'b1;
            ff_op    <= cap_op;
            ff_a     <= cap_a;
            ff_b     <= cap_b;
            ff_got   <= rsp_result;
            ff_exp   <= cap_exp;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_response_checker.sv
// Bench for alu_response_checker: directed scenarios followed by random traffic,
// every cycle compared against a queue-based scoreboard model.
module tb_alu_response_checker;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_a = '0, req_b = '0;
  logic [3:0] req_op = '0;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_result = '0;
  logic       rsp_zero = 1'b0;

  logic        chk_pass, chk_fail, err_sticky, q_overflow, orphan_rsp, ff_valid;
  logic [15:0] pass_count, fail_count;
  logic [2:0]  outstanding;
  logic [3:0]  ff_op;
  logic [7:0]  ff_a, ff_b, ff_got, ff_exp;

  logic        s_chk_pass, s_chk_fail, s_err, s_ovf, s_orph, s_ffv;
  logic [1:0]  s_pass_count, s_fail_count;
  logic [2:0]  s_outstanding;
  logic [3:0]  s_ff_op;
  logic [7:0]  s_ff_a, s_ff_b, s_ff_got, s_ff_exp;

  alu_response_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .chk_pass(chk_pass), .chk_fail(chk_fail),
    .pass_count(pass_count), .fail_count(fail_count),
    .err_sticky(err_sticky), .q_overflow(q_overflow), .orphan_rsp(orphan_rsp),
    .outstanding(outstanding), .ff_valid(ff_valid), .ff_op(ff_op),
    .ff_a(ff_a), .ff_b(ff_b), .ff_got(ff_got), .ff_exp(ff_exp)
  );

  // Narrow-counter instance on the same traffic, used for saturation.
  alu_response_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) sat (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .chk_pass(s_chk_pass), .chk_fail(s_chk_fail),
    .pass_count(s_pass_count), .fail_count(s_fail_count),
    .err_sticky(s_err), .q_overflow(s_ovf), .orphan_rsp(s_orph),
    .outstanding(s_outstanding), .ff_valid(s_ffv), .ff_op(s_ff_op),
    .ff_a(s_ff_a), .ff_b(s_ff_b), .ff_got(s_ff_got), .ff_exp(s_ff_exp)
  );

  always #5 clk = ~clk;

  typedef struct { int op; int a; int b; } req_t;

  int   tests = 0, fails = 0;
  req_t m_q[$];
  int   m_pass, m_fail, m_cp, m_cf, m_err, m_ovf, m_orph;
  int   m_ffv, m_ffop, m_ffa, m_ffb, m_ffgot, m_ffexp;

  // Reference ALU result from plain integer arithmetic on 8-bit operands.
  function automatic int ref_exp(int op, int a, int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (b >= WIDTH) ? 0 : (a * (1 << b)) % 256;
      6: return (b >= WIDTH) ? 0 : a / (1 << b);
      7: return (a < b) ? 1 : 0;
      8: return (a == b) ? 1 : 0;
      9: return a;
      default: return 0;
    endcase
  endfunction

  function automatic int min_i(int x, int y);
    return (x < y) ? x : y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_cp = 0; m_cf = 0; m_err = 0; m_ovf = 0; m_orph = 0;
    m_ffv = 0; m_ffop = 0; m_ffa = 0; m_ffb = 0; m_ffgot = 0; m_ffexp = 0;
  endtask

  task automatic m_fail_evt(input int op, input int a, input int b, input int got, input int e);
    m_fail++; m_cf = 1; m_err = 1;
    if (m_ffv == 0) begin
      m_ffv = 1; m_ffop = op; m_ffa = a; m_ffb = b; m_ffgot = got; m_ffexp = e;
    end
  endtask

  // Scoreboard update for one rising edge with the currently driven inputs.
  task automatic m_edge();
    req_t h, r;
    int   e;
    m_cp = 0; m_cf = 0;
    if (clear) begin
      m_reset();
      return;
    end
    if (rsp_valid) begin
      if (m_q.size() == 0) begin
        m_orph = 1;
        m_fail_evt(0, 0, 0, int'(rsp_result), 0);
      end else begin
        h = m_q.pop_front();
        e = ref_exp(h.op, h.a, h.b);
        if (int'(rsp_result) == e && int'(rsp_zero) == ((e == 0) ? 1 : 0)) begin
          m_pass++; m_cp = 1;
        end else begin
          m_fail_evt(h.op, h.a, h.b, int'(rsp_result), e);
        end
      end
    end
    if (req_valid) begin
      if (m_q.size() < DEPTH) begin
        r.op = int'(req_op); r.a = int'(req_a); r.b = int'(req_b);
        m_q.push_back(r);
      end else begin
        m_ovf = 1; m_err = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("chk_pass",    chk_pass,    m_cp);
    chk("chk_fail",    chk_fail,    m_cf);
    chk("pass_count",  pass_count,  min_i(m_pass, 65535));
    chk("fail_count",  fail_count,  min_i(m_fail, 65535));
    chk("err_sticky",  err_sticky,  m_err);
    chk("q_overflow",  q_overflow,  m_ovf);
    chk("orphan_rsp",  orphan_rsp,  m_orph);
    chk("outstanding", outstanding, m_q.size());
    chk("ff_valid",    ff_valid,    m_ffv);
    chk("ff_op",       ff_op,       m_ffop);
    chk("ff_a",        ff_a,        m_ffa);
    chk("ff_b",        ff_b,        m_ffb);
    chk("ff_got",      ff_got,      m_ffgot);
    chk("ff_exp",      ff_exp,      m_ffexp);
    chk("sat_pass",    s_pass_count, min_i(m_pass, 3));
    chk("sat_fail",    s_fail_count, min_i(m_fail, 3));
  endtask

  // One clock: drive at the falling edge, update model at the rising edge, sample 1ns later.
  task automatic step(input logic cl, input logic rv, input int op, input int a, input int b,
                      input logic sv, input int res, input logic z);
    @(negedge clk);
    clear = cl; req_valid = rv; req_op = op[3:0]; req_a = a[7:0]; req_b = b[7:0];
    rsp_valid = sv; rsp_result = res[7:0]; rsp_zero = z;
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Correct response for a request, as a good ALU would return it.
  task automatic good_rsp(input req_t r, input logic rv, input int op, input int a, input int b);
    int e;
    e = ref_exp(r.op, r.a, r.b);
    step(0, rv, op, a, b, 1, e, (e == 0));
  endtask

  req_t reqs[$];
  req_t t;

  initial begin
    m_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Scenario 1: ADD 05+03 -> 08 over a 1-cycle pipe
    step(0, 1, 0, 8'h05, 8'h03, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8'h08, 0);
    chk("s1_pulse", chk_pass, 1);
    chk("s1_cnt", pass_count, 1);
    idle();
    chk("s1_pulse_end", chk_pass, 0);

    // Scenario 2: SUB 10-05 answered with 0A; second bad response keeps the capture
    do_clear();
    step(0, 1, 1, 8'h10, 8'h05, 0, 0, 0);
    step(0, 1, 0, 8'h01, 8'h01, 1, 8'h0A, 0);
    chk("s2_fail", chk_fail, 1);
    chk("s2_ffexp", ff_exp, 8'h0B);
    chk("s2_ffgot", ff_got, 8'h0A);
    step(0, 0, 0, 0, 0, 1, 8'h00, 1);
    chk("s2_ffop_kept", ff_op, 1);
    chk("s2_ffa_kept", ff_a, 8'h10);
    chk("s2_fail_cnt", fail_count, 2);

    // Scenario 3: 19 back-to-back ops over a 2-cycle pipe
    do_clear();
    reqs.delete();
    for (int i = 0; i < 19; i++) begin
      t.op = i % 16; t.a = $urandom_range(0, 255);
      t.b = (t.op == 5 || t.op == 6) ? $urandom_range(0, 10) : $urandom_range(0, 255);
      if (i == 8) t.b = t.a;
      reqs.push_back(t);
    end
    for (int i = 0; i < 21; i++) begin
      if (i >= 2) good_rsp(reqs[i-2], i < 19, (i < 19) ? reqs[i].op : 0,
                           (i < 19) ? reqs[i].a : 0, (i < 19) ? reqs[i].b : 0);
      else step(0, 1, reqs[i].op, reqs[i].a, reqs[i].b, 0, 0, 0);
    end
    chk("s3_pass", pass_count, 19);
    chk("s3_fail", fail_count, 0);
    chk("s3_out", outstanding, 0);

    // Scenario 4: overflow with DEPTH=4, then drain
    do_clear();
    reqs.delete();
    for (int i = 0; i < 5; i++) begin
      t.op = i; t.a = $urandom_range(0, 255); t.b = $urandom_range(0, 7);
      reqs.push_back(t);
      step(0, 1, t.op, t.a, t.b, 0, 0, 0);
    end
    chk("s4_ovf", q_overflow, 1);
    chk("s4_out", outstanding, 4);
    for (int i = 0; i < 4; i++) good_rsp(reqs[i], 0, 0, 0, 0);
    chk("s4_pass", pass_count, 4);

    // Scenario 5: orphan, then SHL by WIDTH expects 00
    do_clear();
    step(0, 0, 0, 0, 0, 1, 8'h33, 0);
    chk("s5_orph", orphan_rsp, 1);
    chk("s5_fail", fail_count, 1);
    step(0, 1, 5, 8'h01, 8'h08, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 8'h00, 1);
    chk("s5_shl", chk_pass, 1);

    // Scenario 6: narrow counter saturation, then clear
    do_clear();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(0, 1, 9, 8'h07, 0, 0, 0, 0);
      else begin t.op = 9; t.a = 7; t.b = 0; good_rsp(t, i < 5, 9, 8'h07, 0); end
    end
    chk("s6_sat", s_pass_count, 3);
    chk("s6_wide", pass_count, 5);
    // Full and empty boundary with simultaneous push and pop
    step(0, 1, 9, 8'h07, 0, 1, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 4, i, 1, 0, 0, 0);
    t.op = 4; t.a = 0; t.b = 1;
    good_rsp(t, 1, 2, 8'hF0, 8'h3C);
    chk("s6_full_pp", outstanding, 4);
    do_clear();
    chk("s6_clr_pass", pass_count, 0);
    chk("s6_clr_err", err_sticky, 0);

    // Random traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      logic rv, sv, z, cl;
      int   op, a, b, res, e;
      cl = ($urandom_range(0, 79) == 0);
      rv = $urandom_range(0, 1);
      sv = ($urandom_range(0, 2) != 0) && ((m_q.size() != 0) || ($urandom_range(0, 7) == 0));
      op = $urandom_range(0, 15); a = $urandom_range(0, 255);
      b = (op == 5 || op == 6) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0) b = a;
      if (m_q.size() != 0) begin
        e = ref_exp(m_q[0].op, m_q[0].a, m_q[0].b);
        res = e; z = (e == 0);
        if ($urandom_range(0, 9) == 0) res = e ^ (1 << $urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) z = ~z;
      end else begin
        res = $urandom_range(0, 255); z = $urandom_range(0, 1);
      end
      step(cl, rv, op, a, b, sv, res, z);
    end

    // Async reset between edges, mid-traffic
    do_clear();
    step(0, 1, 0, 8'h01, 8'h02, 0, 0, 0);
    step(0, 1, 3, 8'h10, 8'h01, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 0, 1, 8'h55, 0);
    @(negedge clk);
    req_valid = 0; rsp_valid = 0; clear = 0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    chk("rst_out_now", outstanding, 0);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 8'h11, 0);
    chk("rst_orphan", orphan_rsp, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
